// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//
// Round-robin arbiter that shares one FIFO write port between NREQ
// requesters. A requester that wins a grant keeps the port for a burst of
// up to MAX_BURST accepted words. Priority then rotates to the requester
// after the one that just finished.
//
// Handshake: req[i] stays high while requester i presents a word on its din
// slice. In the cycle where gnt[i]=1, that word is written into the FIFO at
// the rising clock edge, and the requester must advance to its next word.
// No grant is ever issued while fifo_full_wire=1.
//
// Ports:
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   req[NREQ]      per-requester request
//   din[NREQ*DW]   flattened data; requester i drives din[i*DW +: DW]
//   fifo_full_wire FIFO full flag
//   gnt[NREQ]      one-hot word-accepted strobe (combinational)
//   wr             FIFO write request, equal to |gnt
//   wdata[DW]      data of the granted requester, 0 when wr=0
//   owner[OW]      current burst owner index; meaningful while busy=1
//   busy           1 while the FSM is in BURST (this is the FSM state)
//   stall_cnt[16]  only when FIFO_WR_ARB_STALL_CNT_EN is defined: saturating
//                  count of clocks with req!=0 and fifo_full_wire=1
//
// Optional feature macro: FIFO_WR_ARB_STALL_CNT_EN

module fifo_wr_arbiter #(
    parameter int NREQ      = 4,
    parameter int DW        = 8,
    parameter int MAX_BURST = 4,
    localparam int OW       = $clog2(NREQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*DW-1:0] din,
    input  logic               fifo_full_wire,
    output logic [NREQ-1:0]    gnt,
    output logic               wr,
    output logic [DW-1:0]      wdata,
    output logic [OW-1:0]      owner,
`ifdef FIFO_WR_ARB_STALL_CNT_EN
    output logic [15:0]        stall_cnt,
`endif
    output logic               busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    localparam logic [3:0]    BURST_LEN = 4'(MAX_BURST);
    localparam logic [OW-1:0] LAST_INIT = OW'(NREQ - 1);

    state_t          state, state_n;
    logic [OW-1:0]   owner_n;
    logic [OW-1:0]   last, last_n;
    logic [3:0]      cnt, cnt_n;
    logic [NREQ-1:0] gnt_c;
    logic [OW-1:0]   winner;
    logic            found;

    // Round-robin search starting just after 'last'. Walking the offsets
    // downwards means the final assignment is the smallest offset with
    // a request, which is the highest-priority requester.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int k = NREQ; k >= 1; k--) begin
            if (req[(int'(last) + k) % NREQ]) begin
                winner = OW'((int'(last) + k) % NREQ);
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        state_n = state;
        owner_n = owner;
        last_n  = last;
        cnt_n   = cnt;
        gnt_c   = '0;
        case (state)
            IDLE: begin
                if (!fifo_full_wire && found) begin
                    gnt_c[winner] = 1'b1;
                    owner_n       = winner;
                    cnt_n         = 4'd1;
                    // A one-word burst is already complete, so we rotate at once.
                    if (MAX_BURST == 1) begin
                        last_n = winner;
                    end else begin
                        state_n = BURST;
                    end
                end
            end
            BURST: begin
                if (!req[owner]) begin
                    // The owner has finished early. This cycle is a bubble.
                    last_n  = owner;
                    state_n = IDLE;
                end else if (!fifo_full_wire) begin
                    gnt_c[owner] = 1'b1;
                    cnt_n        = cnt + 4'd1;
                    if (cnt_n == BURST_LEN) begin
                        last_n  = owner;
                        state_n = IDLE;
                    end
                end
                // While the FIFO is full everything holds. A stall does not
                // use up any of the burst budget.
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            owner <= '0;
            last  <= LAST_INIT;
            cnt   <= 4'd0;
        end else begin
            state <= state_n;
            owner <= owner_n;
            last  <= last_n;
            cnt   <= cnt_n;
        end
    end

    // The outputs are combinational, but they are gated with rst_n so they
    // drop to zero as soon as reset is asserted.
    assign gnt  = rst_n ? gnt_c : '0;
    assign wr   = |gnt;
    assign busy = rst_n && (state == BURST);

    always_comb begin
        wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                wdata = din[i*DW +: DW];
            end
        end
    end

`ifdef FIFO_WR_ARB_STALL_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= 16'd0;
        end else if ((|req) && fifo_full_wire && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed testbench for fifo_wr_arbiter with the default parameters
// (NREQ=4, DW=8, MAX_BURST=4). A table of per-cycle vectors covers burst
// rotation, early release, full stalls and full/request collisions.
// Hand-written sequences cover reset asserted mid-burst and, when the
// feature is built in, the stall counter.

module tb_fifo_wr_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 8;

    logic              clk;
    logic              rst_n;
    logic [NREQ-1:0]   req;
    logic [NREQ*DW-1:0] din;
    logic              fifo_full_wire;
    logic [NREQ-1:0]   gnt;
    logic              wr;
    logic [DW-1:0]     wdata;
    logic [1:0]        owner;
    logic              busy;
`ifdef FIFO_WR_ARB_STALL_CNT_EN
    logic [15:0]       stall_cnt;
`endif

    int tests_run;
    int tests_failed;

    fifo_wr_arbiter #(.NREQ(NREQ), .DW(DW), .MAX_BURST(4)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req            (req),
        .din            (din),
        .fifo_full_wire (fifo_full_wire),
        .gnt            (gnt),
        .wr             (wr),
        .wdata          (wdata),
        .owner          (owner),
`ifdef FIFO_WR_ARB_STALL_CNT_EN
        .stall_cnt      (stall_cnt),
`endif
        .busy           (busy)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // one cycle of stimulus plus the outputs expected in that cycle
    typedef struct {
        logic       pre_rst;
        logic [3:0] req;
        logic       full;
        logic [3:0] gnt;
        logic [7:0] wdata;
        logic       busy;
        logic [1:0] owner;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic pr, input logic [3:0] rq, input logic fl,
                                input logic [3:0] g, input logic [7:0] wd,
                                input logic b, input logic [1:0] ow);
        vec_t v;
        v.pre_rst = pr; v.req = rq; v.full = fl;
        v.gnt = g; v.wdata = wd; v.busy = b; v.owner = ow;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // driver: hold reset for two clocks, release it between edges, then
    // return one time step after the next rising edge
    task automatic do_reset();
        rst_n = 1'b0;
        req = 4'b0000;
        fifo_full_wire = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic run_table();
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].pre_rst) do_reset();
            req = vecs[i].req;
            fifo_full_wire = vecs[i].full;
            @(negedge clk);
            chk($sformatf("v%0d.gnt", i),   32'(gnt),   32'(vecs[i].gnt));
            chk($sformatf("v%0d.wr", i),    32'(wr),    32'(|vecs[i].gnt));
            chk($sformatf("v%0d.wdata", i), 32'(wdata), 32'(vecs[i].wdata));
            chk($sformatf("v%0d.busy", i),  32'(busy),  32'(vecs[i].busy));
            chk($sformatf("v%0d.owner", i), 32'(owner), 32'(vecs[i].owner));
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        tests_run = 0;
        tests_failed = 0;
        rst_n = 1'b0;
        req = 4'b1111;
        fifo_full_wire = 1'b0;
        din = 32'h4332_2110;

        // The outputs must stay at zero while reset is asserted, even with
        // requests present.
        #1;
        chk("rst.gnt",   32'(gnt),   32'h0);
        chk("rst.wr",    32'(wr),    32'h0);
        chk("rst.wdata", 32'(wdata), 32'h0);
        chk("rst.busy",  32'(busy),  32'h0);
        chk("rst.owner", 32'(owner), 32'h0);

        // A: all four requesters active; full 4-word bursts in order 0,1,2,3,0
        vecs.push_back(mk(1, 4'hF, 0, 4'h1, 8'h10, 0, 2'd0));
        vecs.push_back(mk(0, 4'hF, 0, 4'h1, 8'h10, 1, 2'd0));
        vecs.push_back(mk(0, 4'hF, 0, 4'h1, 8'h10, 1, 2'd0));
        vecs.push_back(mk(0, 4'hF, 0, 4'h1, 8'h10, 1, 2'd0));
        vecs.push_back(mk(0, 4'hF, 0, 4'h2, 8'h21, 0, 2'd0));
        vecs.push_back(mk(0, 4'hF, 0, 4'h2, 8'h21, 1, 2'd1));
        vecs.push_back(mk(0, 4'hF, 0, 4'h2, 8'h21, 1, 2'd1));
        vecs.push_back(mk(0, 4'hF, 0, 4'h2, 8'h21, 1, 2'd1));
        vecs.push_back(mk(0, 4'hF, 0, 4'h4, 8'h32, 0, 2'd1));
        vecs.push_back(mk(0, 4'hF, 0, 4'h4, 8'h32, 1, 2'd2));
        vecs.push_back(mk(0, 4'hF, 0, 4'h4, 8'h32, 1, 2'd2));
        vecs.push_back(mk(0, 4'hF, 0, 4'h4, 8'h32, 1, 2'd2));
        vecs.push_back(mk(0, 4'hF, 0, 4'h8, 8'h43, 0, 2'd2));
        vecs.push_back(mk(0, 4'hF, 0, 4'h8, 8'h43, 1, 2'd3));
        vecs.push_back(mk(0, 4'hF, 0, 4'h8, 8'h43, 1, 2'd3));
        vecs.push_back(mk(0, 4'hF, 0, 4'h8, 8'h43, 1, 2'd3));
        vecs.push_back(mk(0, 4'hF, 0, 4'h1, 8'h10, 0, 2'd3));
        // B: requester 2 writes twice then drops; bubble, idle, then 3 wins
        vecs.push_back(mk(1, 4'h4, 0, 4'h4, 8'h32, 0, 2'd0));
        vecs.push_back(mk(0, 4'h4, 0, 4'h4, 8'h32, 1, 2'd2));
        vecs.push_back(mk(0, 4'h0, 0, 4'h0, 8'h00, 1, 2'd2));
        vecs.push_back(mk(0, 4'h0, 0, 4'h0, 8'h00, 0, 2'd2));
        vecs.push_back(mk(0, 4'hF, 0, 4'h8, 8'h43, 0, 2'd2));
        // C: five-cycle stall at cnt=2, then exactly two more words
        vecs.push_back(mk(1, 4'hF, 0, 4'h1, 8'h10, 0, 2'd0));
        vecs.push_back(mk(0, 4'hF, 0, 4'h1, 8'h10, 1, 2'd0));
        for (int k = 0; k < 5; k++)
            vecs.push_back(mk(0, 4'hF, 1, 4'h0, 8'h00, 1, 2'd0));
        vecs.push_back(mk(0, 4'hF, 0, 4'h1, 8'h10, 1, 2'd0));
        vecs.push_back(mk(0, 4'hF, 0, 4'h1, 8'h10, 1, 2'd0));
        vecs.push_back(mk(0, 4'hF, 0, 4'h2, 8'h21, 0, 2'd0));
        // D: full and a request arrive together in IDLE; full wins
        vecs.push_back(mk(1, 4'h0, 0, 4'h0, 8'h00, 0, 2'd0));
        vecs.push_back(mk(0, 4'h1, 1, 4'h0, 8'h00, 0, 2'd0));
        vecs.push_back(mk(0, 4'h1, 1, 4'h0, 8'h00, 0, 2'd0));
        vecs.push_back(mk(0, 4'h1, 0, 4'h1, 8'h10, 0, 2'd0));
        vecs.push_back(mk(0, 4'h1, 0, 4'h1, 8'h10, 1, 2'd0));

        run_table();

        // E: reset asserted mid-burst while requester 3 owns the port
        do_reset();
        req = 4'b1000;
        @(posedge clk);
        #1;
        chk("e.gnt_pre",   32'(gnt),   32'h8);
        chk("e.owner_pre", 32'(owner), 32'h3);
        rst_n = 1'b0;
        #1;
        chk("e.gnt_rst",   32'(gnt),   32'h0);
        chk("e.wr_rst",    32'(wr),    32'h0);
        chk("e.wdata_rst", 32'(wdata), 32'h0);
        chk("e.busy_rst",  32'(busy),  32'h0);
        @(negedge clk);
        req = 4'b1001;
        rst_n = 1'b1;
        #1;
        chk("e.gnt_rel",   32'(gnt),   32'h1);
        chk("e.wdata_rel", 32'(wdata), 32'h10);
        @(posedge clk);
        #1;
        chk("e.owner_rel", 32'(owner), 32'h0);
        chk("e.busy_rel",  32'(busy),  32'h1);

`ifdef FIFO_WR_ARB_STALL_CNT_EN
        // F: stall counter counts, then saturates
        do_reset();
        chk("f.stall_rst", 32'(stall_cnt), 32'h0);
        req = 4'b0001;
        fifo_full_wire = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("f.stall_10", 32'(stall_cnt), 32'd10);
        repeat (65524) @(posedge clk);
        #1;
        chk("f.stall_fffe", 32'(stall_cnt), 32'hFFFE);
        @(posedge clk);
        #1;
        chk("f.stall_ffff", 32'(stall_cnt), 32'hFFFF);
        repeat (3) @(posedge clk);
        #1;
        chk("f.stall_sat", 32'(stall_cnt), 32'hFFFF);
        chk("f.no_wr_full", 32'(wr), 32'h0);
`endif

        // final report
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // The FIFO must never receive a write while it reports full.
    always @(negedge clk) begin
        if (rst_n && wr && fifo_full_wire) begin
            tests_run++;
            tests_failed++;
            $display("FAIL wr_while_full: wr=%0b full=%0b, expected wr=0", wr, fifo_full_wire);
        end
    end

endmodule
